// File: rtl/result_writeback_pkg.sv
// Shared definitions for the result writeback path.
// Holds the default geometry constants, the writeback FSM state type, the
// result bundle layout for the default geometry and a helper that gives the
// flattened bundle width for any geometry.
package result_writeback_pkg;

    localparam int unsigned WB_DATA_WIDTH   = 16;
    localparam int unsigned WB_IMAGE_WIDTH  = 8;
    localparam int unsigned WB_IMAGE_HEIGHT = 8;
    localparam int unsigned WB_NUM_UNITS    = 2;
    localparam int unsigned WB_FIFO_DEPTH   = 2;
    localparam int unsigned WB_AW           = $clog2(WB_IMAGE_WIDTH * WB_IMAGE_HEIGHT);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StDone
    } wb_state_e;

    // Bundle layout for the default geometry; parameterised instances use the
    // same field order {mask, relu, addr} in a flat vector.
    typedef struct packed {
        logic [WB_NUM_UNITS-1:0]               mask;
        logic [WB_NUM_UNITS*WB_DATA_WIDTH-1:0] relu;
        logic [WB_NUM_UNITS*WB_AW-1:0]         addr;
    } wb_bundle_t;

    function automatic int unsigned bundle_width(input int unsigned num_units,
                                                 input int unsigned data_width,
                                                 input int unsigned aw);
        return num_units + num_units * data_width + num_units * aw;
    endfunction

endpackage

// File: rtl/result_writeback_fifo.sv
// result_fifo: small synchronous FIFO holding captured result bundles.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   push, wdata   write one entry (caller guarantees space or a same-cycle pop)
//   pop, rdata    rdata shows the head entry; pop removes it
//   full, empty   occupancy flags
// DEPTH must be a power of two, at least 2. Pointers carry one extra wrap bit
// so full and empty are distinguishable when the index bits match.
module result_fifo
    import result_writeback_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = WB_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr_q;
    logic [PW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (PW + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (PW + 1)'(1);
        end
    end

    // Storage needs no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[PW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/result_writeback.sv
// result_writeback: buffers ReLU result bundles from the compute units and
// writes every enabled unit's word to image memory, one at a time.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   tpu_done          completion level; a 0->1 transition captures a bundle
//   done_array        per-unit enable mask captured with the bundle
//   relu_out          per-unit result words, unit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   dest_addr         per-unit destination address, unit i at [i*AW +: AW]
//   mem_we/addr/wdata write request, held until mem_ready at a clock edge
//   mem_ready         memory accepts the current write
//   busy              FIFO non-empty or FSM not idle
//   wb_done           one-cycle pulse per bundle processed
//   overflow          sticky: a bundle was dropped because the FIFO was full
//   clear_overflow    synchronous clear of overflow (a same-cycle drop wins)
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int unsigned IMAGE_WIDTH  = WB_IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = WB_IMAGE_HEIGHT,
    parameter int unsigned NUM_UNITS    = WB_NUM_UNITS,
    parameter int unsigned FIFO_DEPTH   = WB_FIFO_DEPTH,
    localparam int unsigned AW          = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            tpu_done,
    input  logic [NUM_UNITS-1:0]            done_array,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0] relu_out,
    input  logic [NUM_UNITS*AW-1:0]         dest_addr,
    output logic                            mem_we,
    output logic [AW-1:0]                   mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_ready,
    output logic                            busy,
    output logic                            wb_done,
    output logic                            overflow,
    input  logic                            clear_overflow
);

    localparam int unsigned RW  = NUM_UNITS * DATA_WIDTH;
    localparam int unsigned DAW = NUM_UNITS * AW;
    localparam int unsigned BW  = bundle_width(NUM_UNITS, DATA_WIDTH, AW);
    localparam int unsigned IW  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic           tpu_done_q;
    logic           armed_q;
    logic           capture;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [BW-1:0]  fifo_wdata;
    logic [BW-1:0]  fifo_rdata;

    logic [NUM_UNITS-1:0] head_mask;
    logic [RW-1:0]        head_relu;
    logic [DAW-1:0]       head_addr;

    wb_state_e            state_q;
    logic [NUM_UNITS-1:0] pend_q;   // enabled units not yet presented
    logic [RW-1:0]        relu_q;
    logic [DAW-1:0]       addr_q;

    // armed_q blocks a capture in the first cycle after reset, so a tpu_done
    // level that was already high when reset released is not taken as an edge.
    assign capture    = armed_q & tpu_done & ~tpu_done_q;
    assign fifo_pop   = (state_q == StLoad);
    assign fifo_push  = capture & (~fifo_full | fifo_pop);
    assign fifo_wdata = {done_array, relu_out, dest_addr};
    assign {head_mask, head_relu, head_addr} = fifo_rdata;
    assign busy       = ~fifo_empty | (state_q != StIdle);

    result_fifo #(
        .WIDTH (BW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Lowest enabled unit of either the head bundle (LOAD) or the remaining
    // units of the bundle being written (WRITE).
    logic [NUM_UNITS-1:0]  sel_src;
    logic [RW-1:0]         relu_src;
    logic [DAW-1:0]        addr_src;
    logic [IW-1:0]         sel_idx;
    logic                  sel_any;
    logic [NUM_UNITS-1:0]  sel_rest;
    logic [AW-1:0]         sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    always_comb begin
        sel_src  = fifo_pop ? head_mask : pend_q;
        relu_src = fifo_pop ? head_relu : relu_q;
        addr_src = fifo_pop ? head_addr : addr_q;
        sel_idx  = '0;
        sel_any  = 1'b0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (sel_src[i]) begin
                sel_idx = IW'(i);
                sel_any = 1'b1;
            end
        end
        sel_rest = sel_src & ~(NUM_UNITS'(1) << sel_idx);
        sel_addr = addr_src[sel_idx * AW +: AW];
        sel_data = relu_src[sel_idx * DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tpu_done_q <= 1'b0;
            armed_q    <= 1'b0;
            pend_q     <= '0;
            relu_q     <= '0;
            addr_q     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_done    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            tpu_done_q <= tpu_done;
            armed_q    <= 1'b1;
            wb_done    <= 1'b0;

            if (capture && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) state_q <= StLoad;
                end
                StLoad: begin
                    relu_q <= head_relu;
                    addr_q <= head_addr;
                    pend_q <= sel_rest;
                    if (sel_any) begin
                        state_q   <= StWrite;
                        mem_we    <= 1'b1;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_data;
                    end else begin
                        state_q <= StDone;
                        wb_done <= 1'b1;
                    end
                end
                StWrite: begin
                    if (mem_ready) begin
                        if (sel_any) begin
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_data;
                            pend_q    <= sel_rest;
                        end else begin
                            mem_we  <= 1'b0;
                            state_q <= StDone;
                            wb_done <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_writeback.sv
module tb_result_writeback;

    localparam int DW  = 16;
    localparam int NU  = 2;
    localparam int FD  = 2;
    localparam int AW  = 6;
    localparam int RWT = NU * DW;
    localparam int AWT = NU * AW;

    logic           clk = 1'b0;
    logic           reset;
    logic           tpu_done;
    logic [NU-1:0]  done_array;
    logic [RWT-1:0] relu_out;
    logic [AWT-1:0] dest_addr;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           mem_ready;
    logic           busy;
    logic           wb_done;
    logic           overflow;
    logic           clear_overflow;

    logic dir_ready;
    logic rand_ready;
    logic rnd_ready = 1'b1;
    assign mem_ready = rand_ready ? rnd_ready : dir_ready;

    always #5 clk = ~clk;
    always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

    result_writeback #(
        .DATA_WIDTH   (DW),
        .IMAGE_WIDTH  (8),
        .IMAGE_HEIGHT (8),
        .NUM_UNITS    (NU),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tpu_done       (tpu_done),
        .done_array     (done_array),
        .relu_out       (relu_out),
        .dest_addr      (dest_addr),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .busy           (busy),
        .wb_done        (wb_done),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int writes_seen = 0;

    typedef struct {
        bit is_done;
        int addr;
        int data;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: each accepted bundle yields its enabled units in ascending
    // index order, then one completion pulse.
    function automatic void model_push(input logic [NU-1:0] m, input logic [RWT-1:0] r,
                                       input logic [AWT-1:0] a);
        ev_t e;
        for (int i = 0; i < NU; i++) begin
            if (m[i]) begin
                e.is_done = 0;
                e.addr    = int'(a[i*AW +: AW]);
                e.data    = int'(r[i*DW +: DW]);
                exp_q.push_back(e);
            end
        end
        e.is_done = 1;
        e.addr    = 0;
        e.data    = 0;
        exp_q.push_back(e);
    endfunction

    // Monitor: compares accepted writes and completion pulses with the queue.
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_we", mem_we, 1);
                check("hold_addr", mem_addr, prev_addr);
                check("hold_data", mem_wdata, prev_data);
            end
            if (mem_we && mem_ready) begin
                writes_seen++;
                check("write_expected", (exp_q.size() > 0 && !exp_q[0].is_done) ? 1 : 0, 1);
                if (exp_q.size() > 0 && !exp_q[0].is_done) begin
                    check("wr_addr", mem_addr, exp_q[0].addr);
                    check("wr_data", mem_wdata, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
            if (wb_done) begin
                done_seen++;
                check("done_expected", (exp_q.size() > 0 && exp_q[0].is_done) ? 1 : 0, 1);
                if (exp_q.size() > 0 && exp_q[0].is_done) void'(exp_q.pop_front());
            end
            prev_stall = mem_we && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise tpu_done for one edge; returns 1 time unit after the capture edge.
    task automatic capture(input logic [NU-1:0] m, input logic [RWT-1:0] r,
                           input logic [AWT-1:0] a, input bit accept);
        done_array = m;
        relu_out   = r;
        dest_addr  = a;
        tpu_done   = 1'b1;
        if (accept) model_push(m, r, a);
        tick(1);
        tpu_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 500) begin
            tick(1);
            n++;
        end
        check(name, (busy || exp_q.size() != 0) ? 1 : 0, 0);
    endtask

    logic [RWT-1:0] d75 = {16'd7, 16'd5};
    logic [AWT-1:0] a2120 = {6'd21, 6'd20};

    initial begin
        int d0;
        int w0;
        int acc;
        int base;
        int guard;
        logic [NU-1:0]  rm;
        logic [RWT-1:0] rr;
        logic [AWT-1:0] ra;

        reset          = 1'b1;
        tpu_done       = 1'b0;
        done_array     = '0;
        relu_out       = '0;
        dest_addr      = '0;
        clear_overflow = 1'b0;
        dir_ready      = 1'b1;
        rand_ready     = 1'b0;
        tick(2);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_wb_done", wb_done, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        tick(2);

        // Both units, memory always ready: latency and ordering.
        d0 = done_seen; w0 = writes_seen;
        capture(2'b11, d75, a2120, 1);
        check("lat_e1_we", mem_we, 0);
        tick(1);
        check("lat_e2_we", mem_we, 0);
        tick(1);
        check("lat_e3_we", mem_we, 1);
        check("t1_first_addr", mem_addr, 20);
        check("t1_first_data", mem_wdata, 5);
        tick(1);
        check("t1_second_we", mem_we, 1);
        check("t1_second_addr", mem_addr, 21);
        check("t1_second_data", mem_wdata, 7);
        tick(1);
        check("t1_wb_done", wb_done, 1);
        check("t1_we_off", mem_we, 0);
        wait_idle("t1_idle");
        check("t1_done_cnt", done_seen - d0, 1);
        check("t1_write_cnt", writes_seen - w0, 2);

        // Only unit 1 enabled.
        d0 = done_seen; w0 = writes_seen;
        capture(2'b10, d75, a2120, 1);
        wait_idle("t2_idle");
        check("t2_done_cnt", done_seen - d0, 1);
        check("t2_write_cnt", writes_seen - w0, 1);

        // Empty mask: no writes, one pulse.
        d0 = done_seen; w0 = writes_seen;
        capture(2'b00, d75, a2120, 1);
        wait_idle("t3_idle");
        check("t3_done_cnt", done_seen - d0, 1);
        check("t3_write_cnt", writes_seen - w0, 0);
        check("t3_busy", busy, 0);

        // Memory stalls 4 cycles on the first write.
        dir_ready = 1'b0;
        capture(2'b11, d75, a2120, 1);
        tick(2);
        for (int k = 0; k < 5; k++) begin
            check("t4_stall_we", mem_we, 1);
            check("t4_stall_addr", mem_addr, 20);
            check("t4_stall_data", mem_wdata, 5);
            if (k < 4) tick(1);
        end
        dir_ready = 1'b1;
        tick(1);
        check("t4_next_addr", mem_addr, 21);
        check("t4_next_data", mem_wdata, 7);
        wait_idle("t4_idle");

        // Overflow: one bundle stalled in WRITE, two buffered, third dropped.
        d0 = done_seen; w0 = writes_seen;
        dir_ready = 1'b0;
        capture(2'b01, {16'd11, 16'd10}, {6'd1, 6'd0}, 1);
        tick(2);
        check("t5_stalled_we", mem_we, 1);
        tick(1);
        capture(2'b11, {16'd13, 16'd12}, {6'd3, 6'd2}, 1);
        tick(1);
        capture(2'b10, {16'd15, 16'd14}, {6'd5, 6'd4}, 1);
        tick(1);
        check("t5_no_ovf_yet", overflow, 0);
        capture(2'b11, {16'd17, 16'd16}, {6'd7, 6'd6}, 0);
        check("t5_ovf_set", overflow, 1);
        tick(3);
        check("t5_ovf_sticky", overflow, 1);
        dir_ready = 1'b1;
        wait_idle("t5_idle");
        check("t5_done_cnt", done_seen - d0, 3);
        check("t5_write_cnt", writes_seen - w0, 4);
        clear_overflow = 1'b1;
        tick(1);
        clear_overflow = 1'b0;
        check("t5_ovf_clear", overflow, 0);

        // Reset mid-write, with tpu_done held high across reset release.
        dir_ready = 1'b0;
        capture(2'b11, d75, a2120, 1);
        tick(2);
        check("t6_in_write", mem_we, 1);
        tpu_done = 1'b1;
        reset = 1'b1;
        #1;
        check("t6_rst_we", mem_we, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_data", mem_wdata, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_wb_done", wb_done, 0);
        exp_q.delete();
        d0 = done_seen; w0 = writes_seen;
        tick(2);
        reset = 1'b0;
        dir_ready = 1'b1;
        tick(6);
        check("t6_no_capture_busy", busy, 0);
        check("t6_no_done", done_seen - d0, 0);
        check("t6_no_write", writes_seen - w0, 0);
        tpu_done = 1'b0;
        tick(2);

        // Randomised traffic, issued only while a FIFO slot is guaranteed free.
        rand_ready = 1'b1;
        base = done_seen;
        acc = 0;
        for (int b = 0; b < 40; b++) begin
            guard = 0;
            while ((acc - (done_seen - base)) >= FD && guard < 300) begin
                tick(1);
                guard++;
            end
            check("rand_slot_wait", ((acc - (done_seen - base)) < FD) ? 1 : 0, 1);
            rm = NU'($urandom);
            rr = RWT'($urandom);
            ra = AWT'($urandom);
            done_array = rm;
            relu_out   = rr;
            dest_addr  = ra;
            tpu_done   = 1'b1;
            model_push(rm, rr, ra);
            acc++;
            tick($urandom_range(1, 3));
            tpu_done = 1'b0;
            tick($urandom_range(1, 3));
        end
        wait_idle("rand_idle");
        check("rand_done_cnt", done_seen - base, acc);
        check("rand_no_ovf", overflow, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_writeback.md
RESULT_WRITEBACK -- requirements
Module: result_writeback

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one ReLU result word.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 8: image columns.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 8: image rows; AW = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT).
REQ-004 SHALL have parameter NUM_UNITS, default 2: parallel compute units feeding this block.
REQ-005 SHALL have parameter FIFO_DEPTH, default 2: number of buffered result bundles, a power of two.
REQ-006 SHALL have port clk  input  1: single clock, all state on the rising edge.
REQ-007 SHALL have port reset  input  1: asynchronous, active-high.
REQ-008 SHALL have port tpu_done  input  1: completion level from the upstream tensor processing unit.
REQ-009 SHALL have port done_array  input  NUM_UNITS: per-unit enable mask, sampled with the results.
REQ-010 SHALL have port relu_out  input  NUM_UNITS x DATA_WIDTH: per-unit ReLU results.
REQ-011 SHALL have port dest_addr  input  NUM_UNITS x AW: per-unit destination memory address.
REQ-012 SHALL have port mem_we  output  1: write request to image memory.
REQ-013 SHALL have port mem_addr  output  AW: write address.
REQ-014 SHALL have port mem_wdata  output  DATA_WIDTH: write data.
REQ-015 SHALL have port mem_ready  input  1: memory accepts the write at the current edge.
REQ-016 SHALL have port busy  output  1: FIFO non-empty or FSM not IDLE.
REQ-017 SHALL have port wb_done  output  1: one-cycle pulse after a bundle is fully written.
REQ-018 SHALL have port overflow  output  1: sticky flag, bundle dropped.
REQ-019 SHALL have port clear_overflow  input  1: synchronous clear of overflow.

Function
REQ-020 SHALL capture {done_array, relu_out, dest_addr} into the FIFO on a rising edge of tpu_done (tpu_done=1, registered previous=0), one push per edge.
REQ-021 SHALL, when the FIFO is full at a capture edge, drop the bundle and set overflow; clear_overflow and a simultaneous drop SHALL leave overflow set.
REQ-022 SHALL allow push and pop in the same cycle, including when full (the pop frees the slot, no drop).
REQ-023 SHALL use FSM states IDLE, LOAD, WRITE, DONE: IDLE->LOAD when FIFO non-empty; LOAD pops head and selects lowest enabled unit; LOAD->WRITE if mask non-zero, else ->DONE; WRITE->DONE after last enabled unit accepted; DONE->IDLE unconditionally.
REQ-024 SHALL, in WRITE, assert mem_we with mem_addr/mem_wdata of the current unit held stable until mem_ready=1 at a clock edge, then advance to the next higher-index enabled unit.
REQ-025 SHALL skip units whose mask bit is 0; all-zero mask SHALL produce no writes but still pulse wb_done.
REQ-026 SHALL assert wb_done only in DONE, exactly one cycle per popped bundle.
REQ-027 SHALL keep mem_we=0 outside WRITE; mem_addr/mem_wdata are don't-care when mem_we=0 but SHALL be 0 after reset.
REQ-028 SHALL give minimum latency, capture edge to first mem_we, of 3 cycles (push, IDLE->LOAD, LOAD->WRITE).
REQ-029 SHALL treat FIFO pointers modulo FIFO_DEPTH with an extra wrap bit for full/empty.

Reset
REQ-030 SHALL on reset: FSM=IDLE, FIFO empty, edge-detect register=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, wb_done=0, overflow=0.
REQ-031 SHALL abort any in-progress write on reset mid-operation; the partially written bundle is lost, with no further mem_we.
REQ-032 SHALL not capture a bundle if tpu_done is already high when reset deasserts (edge register resets to 0, so the first cycle after reset sees only that level; capture requires a 0->1 transition observed after reset).

Structure
REQ-033 SHALL place the state enum and bundle struct typedef in the shared TPU package alongside DATA_WIDTH/AW constants.
REQ-034 SHALL implement the FIFO as one sub-module, result_fifo, parameterised by bundle width and FIFO_DEPTH.

Verification
REQ-035 SHALL test: mask 2'b11, relu_out {7,5}, dest_addr {21,20}, mem_ready=1 -> writes (20,5) then (21,7) on consecutive cycles, first mem_we 3 cycles after edge, then wb_done pulse.
REQ-036 SHALL test: mask 2'b10, same data -> single write (21,7), wb_done once.
REQ-037 SHALL test: mask 2'b00 -> no mem_we, wb_done one pulse, busy returns 0.
REQ-038 SHALL test: mem_ready low 4 cycles during first write -> mem_we, addr 20, data 5 held for 5 cycles; second write follows.
REQ-039 SHALL test: three capture edges while mem_ready=0, FIFO_DEPTH=2 -> overflow=1, exactly two bundles written once ready rises; clear_overflow returns it to 0.
REQ-040 SHALL test: reset asserted during WRITE -> mem_we drops immediately, all outputs at reset values, no wb_done.
